// File: rtl/boron_inv_round_seq_if.sv
// Handshake/bus bundle for the BORON inverse-round engine.
// The master drives start, initial state and round keys; the slave is the engine.
interface boron_inv_round_seq_if #(
  parameter int unsigned RW = 5
);
  localparam int unsigned DW = 64;

  logic          start_i;
  logic [DW-1:0] data_i;
  logic          busy_o;
  logic          key_req_o;
  logic [RW-1:0] round_o;
  logic          key_valid_i;
  logic [DW-1:0] rk_i;
  logic          done_o;
  logic [DW-1:0] data_o;

  modport master (
    output start_i, data_i, key_valid_i, rk_i,
    input  busy_o, key_req_o, round_o, done_o, data_o
  );

  modport slave (
    input  start_i, data_i, key_valid_i, rk_i,
    output busy_o, key_req_o, round_o, done_o, data_o
  );
endinterface

// File: rtl/boron_inv_round_seq.sv
// Iterative BORON inverse linear layer: one key-add + inverse permutation per cycle,
// keys requested from index ROUNDS-1 down to 0.
module boron_inv_round_seq #(
  parameter int unsigned ROUNDS = 25,
  parameter int unsigned RW     = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  boron_inv_round_seq_if.slave  bus
);
  localparam int unsigned DW = 64;
  localparam int unsigned WW = 16;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  logic [RW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          fire_c;

  function automatic logic [WW-1:0] rotr(input logic [WW-1:0] w, input int unsigned n);
    logic [WW-1:0] lo;
    logic [WW-1:0] hi;
    lo = w >> n;
    hi = w << (WW - n);
    return lo | hi;
  endfunction

  // Undoes the forward per-word rotl 1/4/7/9.
  function automatic logic [DW-1:0] inv_perm(input logic [DW-1:0] s);
    return {rotr(s[63:48], 9), rotr(s[47:32], 7), rotr(s[31:16], 4), rotr(s[15:0], 1)};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    fire_c  = (state_q == RUN) && bus.key_valid_i;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          state_d = RUN;
          data_d  = bus.data_i;
          cnt_d   = RW'(ROUNDS - 1);
        end
      end
      RUN: begin
        // No key means stall: state and count hold.
        if (fire_c) begin
          data_d = inv_perm(data_q ^ bus.rk_i);
          if (cnt_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - RW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy_o    = (state_q == RUN);
  assign bus.key_req_o = (state_q == RUN);
  assign bus.round_o   = cnt_q;
  assign bus.done_o    = done_q;
  assign bus.data_o    = data_q;
endmodule

// File: tb/tb_boron_inv_round_seq.sv
// Bench for boron_inv_round_seq: directed ROUNDS=1 vectors plus ROUNDS=25 round trips
// against a forward-cipher reference, with stalls, ignored/back-to-back starts and reset.
module tb_boron_inv_round_seq;
  localparam int unsigned NR = 25;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [63:0] keys [NR];

  boron_inv_round_seq_if #(.RW(1)) bus1 ();
  boron_inv_round_seq_if #(.RW(5)) bus25 ();

  boron_inv_round_seq #(.ROUNDS(1), .RW(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  boron_inv_round_seq #(.ROUNDS(NR), .RW(5)) dut25 (
    .clk (clk),
    .rst (rst),
    .bus (bus25)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rotl16(input logic [15:0] w, input int n);
    logic [31:0] d;
    d = {w, w} << n;
    return d[31:16];
  endfunction

  // Forward BORON permutation: rotl 1/4/7/9 on w0..w3.
  function automatic logic [63:0] perm(input logic [63:0] s);
    return {rotl16(s[63:48], 9), rotl16(s[47:32], 7), rotl16(s[31:16], 4), rotl16(s[15:0], 1)};
  endfunction

  // Forward model whose inverse the engine computes when fed keys NR-1..0.
  function automatic logic [63:0] enc(input logic [63:0] pt);
    logic [63:0] c;
    c = pt;
    for (int r = 0; r < int'(NR); r++) c = perm(c) ^ keys[r];
    return c;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Runs one ROUNDS=25 block; with skip_start the block was already started.
  task automatic run25(input logic [63:0] pt, input int st24_in, input int st0_in,
                       input bit mid_start, input bit skip_start,
                       input bit chain, input logic [63:0] pt2);
    logic [63:0] ct;
    logic [63:0] held;
    int   exp_r;
    int   ncyc;
    int   st24;
    int   st0;
    bit   fire;
    bit   finished;
    ct = enc(pt);
    st24 = st24_in;
    st0 = st0_in;
    if (!skip_start) begin
      bus25.start_i = 1'b1;
      bus25.data_i  = ct;
      tick();
      bus25.start_i = 1'b0;
    end
    exp_r = NR - 1;
    ncyc = 0;
    finished = 1'b0;
    for (int c = 0; c < 200; c++) begin
      chk("busy_run", 64'(bus25.busy_o), 64'(1));
      chk("key_req_run", 64'(bus25.key_req_o), 64'(1));
      chk("round_seq", 64'(bus25.round_o), 64'(exp_r));
      chk("done_low_run", 64'(bus25.done_o), 64'(0));
      fire = 1'b0;
      bus25.start_i = 1'b0;
      if (mid_start && exp_r == 10) begin
        bus25.start_i = 1'b1;
        bus25.data_i  = ~ct;
      end
      if (exp_r == int'(NR) - 1 && st24 > 0) begin
        bus25.key_valid_i = 1'b0;
        bus25.rk_i = rnd64();
        st24--;
      end else if (exp_r == 0 && st0 > 0) begin
        bus25.key_valid_i = 1'b0;
        bus25.rk_i = rnd64();
        st0--;
      end else begin
        bus25.key_valid_i = 1'b1;
        bus25.rk_i = keys[exp_r];
        fire = 1'b1;
      end
      held = bus25.data_o;
      tick();
      ncyc++;
      if (!fire) chk("stall_hold", bus25.data_o, held);
      if (fire) begin
        if (exp_r == 0) begin
          finished = 1'b1;
          break;
        end
        exp_r--;
      end
    end
    bus25.key_valid_i = 1'b0;
    bus25.start_i = 1'b0;
    chk("block_finished", 64'(finished), 64'(1));
    chk("done_pulse", 64'(bus25.done_o), 64'(1));
    chk("busy_after", 64'(bus25.busy_o), 64'(0));
    chk("round_trip", bus25.data_o, pt);
    chk("latency", 64'(ncyc), 64'(int'(NR) + st24_in + st0_in));
    if (chain) begin
      bus25.start_i = 1'b1;
      bus25.data_i  = enc(pt2);
      tick();
      bus25.start_i = 1'b0;
      chk("b2b_busy", 64'(bus25.busy_o), 64'(1));
      chk("b2b_round", 64'(bus25.round_o), 64'(NR - 1));
    end else begin
      tick();
      chk("done_one_cycle", 64'(bus25.done_o), 64'(0));
      chk("result_hold", bus25.data_o, pt);
    end
  endtask

  initial begin
    logic [63:0] pa;
    logic [63:0] pb;
    logic [63:0] d;
    logic [63:0] k;
    logic [63:0] held;
    int exp_r;
    clk = 1'b0;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus1.start_i = 1'b0;  bus1.data_i = '0;  bus1.key_valid_i = 1'b0;  bus1.rk_i = '0;
    bus25.start_i = 1'b0; bus25.data_i = '0; bus25.key_valid_i = 1'b0; bus25.rk_i = '0;
    for (int r = 0; r < int'(NR); r++) keys[r] = rnd64();

    // Reset state.
    #12;
    chk("rst_busy", 64'(bus25.busy_o), 64'(0));
    chk("rst_key_req", 64'(bus25.key_req_o), 64'(0));
    chk("rst_round", 64'(bus25.round_o), 64'(0));
    chk("rst_done", 64'(bus25.done_o), 64'(0));
    chk("rst_data", bus25.data_o, 64'(0));
    chk("rst_data1", bus1.data_o, 64'(0));
    tick();
    rst = 1'b0;
    tick();

    // ROUNDS=1 single round, zero key.
    bus1.start_i = 1'b1;
    bus1.data_i  = 64'h0001_0001_0001_0001;
    tick();
    bus1.start_i = 1'b0;
    chk("r1_busy", 64'(bus1.busy_o), 64'(1));
    chk("r1_round", 64'(bus1.round_o), 64'(0));
    bus1.key_valid_i = 1'b1;
    bus1.rk_i = '0;
    tick();
    bus1.key_valid_i = 1'b0;
    chk("r1_done", 64'(bus1.done_o), 64'(1));
    chk("r1_data", bus1.data_o, 64'h0080_0200_1000_8000);
    tick();
    chk("r1_done_low", 64'(bus1.done_o), 64'(0));

    // ROUNDS=1 key add.
    bus1.start_i = 1'b1;
    bus1.data_i  = '0;
    tick();
    bus1.start_i = 1'b0;
    chk("ka_key_req", 64'(bus1.key_req_o), 64'(1));
    chk("ka_round", 64'(bus1.round_o), 64'(0));
    bus1.key_valid_i = 1'b1;
    bus1.rk_i = 64'hFFFF_0000_FFFF_0000;
    tick();
    bus1.key_valid_i = 1'b0;
    chk("ka_done", 64'(bus1.done_o), 64'(1));
    chk("ka_data", bus1.data_o, 64'hFFFF_0000_FFFF_0000);

    // Keys offered in IDLE are ignored.
    held = bus1.data_o;
    bus1.key_valid_i = 1'b1;
    bus1.rk_i = rnd64();
    tick();
    tick();
    bus1.key_valid_i = 1'b0;
    chk("idle_key_ignored", bus1.data_o, held);
    chk("idle_busy", 64'(bus1.busy_o), 64'(0));

    // ROUNDS=1 random: forward permutation of the result must give data^key.
    for (int i = 0; i < 4; i++) begin
      d = rnd64();
      k = rnd64();
      bus1.start_i = 1'b1;
      bus1.data_i  = d;
      tick();
      bus1.start_i = 1'b0;
      bus1.key_valid_i = 1'b1;
      bus1.rk_i = k;
      tick();
      bus1.key_valid_i = 1'b0;
      chk("r1_rand_done", 64'(bus1.done_o), 64'(1));
      chk("r1_rand_data", perm(bus1.data_o), d ^ k);
    end

    // ROUNDS=25 round trip, no stalls.
    pa = rnd64();
    run25(pa, 0, 0, 1'b0, 1'b0, 1'b0, '0);

    // Stalls before rounds 24 and 0.
    run25(pa, 3, 3, 1'b0, 1'b0, 1'b0, '0);

    // Ignored mid-block start, then back-to-back block from the done cycle.
    pb = rnd64();
    run25(pa, 0, 0, 1'b1, 1'b0, 1'b1, pb);
    run25(pb, 0, 0, 1'b0, 1'b1, 1'b0, '0);

    // Reset while round_o = 12.
    bus25.start_i = 1'b1;
    bus25.data_i  = enc(pa);
    tick();
    bus25.start_i = 1'b0;
    exp_r = NR - 1;
    for (int c = 0; c < 40 && exp_r > 12; c++) begin
      bus25.key_valid_i = 1'b1;
      bus25.rk_i = keys[exp_r];
      tick();
      exp_r--;
    end
    chk("pre_rst_round", 64'(bus25.round_o), 64'(12));
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 64'(bus25.busy_o), 64'(0));
    chk("mid_rst_key_req", 64'(bus25.key_req_o), 64'(0));
    chk("mid_rst_round", 64'(bus25.round_o), 64'(0));
    chk("mid_rst_done", 64'(bus25.done_o), 64'(0));
    chk("mid_rst_data", bus25.data_o, 64'(0));
    tick();
    tick();
    rst = 1'b0;
    bus25.key_valid_i = 1'b0;
    tick();
    chk("post_rst_done", 64'(bus25.done_o), 64'(0));
    chk("post_rst_busy", 64'(bus25.busy_o), 64'(0));
    pb = rnd64();
    run25(pb, 1, 2, 1'b0, 1'b0, 1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
